// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the main-memory arbiter: FSM
//            state encoding, default bus widths and watchdog sizing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int C_ADDR_W   = 16;   // byte address width
    localparam int C_LINE_W   = 64;   // cache line / memory data width
    localparam int C_WDOG_MAX = 31;   // BUSY cycles allowed before abort
    localparam int C_WDOG_W   = 5;    // watchdog counter width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_TURN   = 2'd3
    } arb_state_t;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the I-cache, D-cache and memory-side signals of the
//            arbiter. The arbiter connects through modport slave; the
//            surrounding caches/memory (or a bench) use modport master.
// Ports    : I side  : i_req, i_addr -> i_rdy
//            D side  : d_req, d_we, d_addr, d_wdata -> d_rdy, d_inProg
//            Memory  : mem_rdy, mem_rdata -> mem_re, mem_we, mem_addr,
//                      mem_wdata
//            Shared  : rdata (read line), wdog_err (sticky abort flag)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int LINE_W = C_LINE_W
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              mem_rdy;
    logic [LINE_W-1:0] mem_rdata;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              i_rdy;
    logic              d_rdy;
    logic [LINE_W-1:0] rdata;
    logic              d_inProg;
    logic              wdog_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdy, mem_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata, i_rdy, d_rdy, rdata,
               d_inProg, wdog_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdy, mem_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata, i_rdy, d_rdy, rdata,
               d_inProg, wdog_err
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_wdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_wdog
// Purpose  : Grant watchdog. Counts BUSY cycles of the current grant and
//            signals an abort when the grant has been open WDOG_MAX cycles
//            without completion. The error flag is sticky until reset.
// Ports    : clk, rst_n  - clock, async active-low reset
//            clr_i       - hold counter at zero (arbiter not busy)
//            en_i        - count this cycle (arbiter busy)
//            done_i      - memory completion this cycle
//            expire_o    - abort the current grant this cycle
//            err_o       - sticky watchdog error
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_wdog
    import mem_arbiter_pkg::*;
#(
    parameter int WDOG_MAX = C_WDOG_MAX
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic en_i,
    input  wire logic done_i,
    output logic      expire_o,
    output logic      err_o
);

    logic [C_WDOG_W-1:0] cnt_q;
    logic                err_q;

    // The counter reads 0 in the first BUSY cycle, so WDOG_MAX-1 marks the
    // WDOG_MAX-th cycle. A completion in that same cycle takes precedence.
    assign expire_o = en_i & ~done_i & (cnt_q == C_WDOG_W'(WDOG_MAX - 1));
    assign err_o    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (clr_i) begin
                cnt_q <= '0;
            end else if (en_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expire_o) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule : mem_arbiter_wdog
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one multi-cycle main memory between the I-cache fill path
//            and the D-cache fill/writeback path. Grants one requester at a
//            time, drives registered memory strobes/address/data, routes the
//            completion pulse back, and aborts hung grants via a watchdog.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mem_arbiter_if.slave (cache and memory signals)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = C_ADDR_W,
    parameter int LINE_W   = C_LINE_W,
    parameter int WDOG_MAX = C_WDOG_MAX
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state_q;
    logic              last_d_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic w_d_wins;
    logic w_busy;
    logic w_expire;
    logic w_wdog_err;

    // D normally has priority, but a pending I request wins right after a
    // D grant so the I side can never be starved by back-to-back D traffic.
    assign w_d_wins = bus.d_req & ~(bus.i_req & last_d_q);
    assign w_busy   = (state_q == ST_I_BUSY) | (state_q == ST_D_BUSY);

    mem_arbiter_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == ST_IDLE),
        .en_i     (w_busy),
        .done_i   (bus.mem_rdy),
        .expire_o (w_expire),
        .err_o    (w_wdog_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_d_wins) begin
                        state_q  <= ST_D_BUSY;
                        last_d_q <= 1'b1;
                        addr_q   <= bus.d_addr;
                        mem_re_q <= ~bus.d_we;
                        mem_we_q <= bus.d_we;
                        if (bus.d_we) begin
                            wdata_q <= bus.d_wdata;
                        end
                    end else if (bus.i_req) begin
                        state_q  <= ST_I_BUSY;
                        last_d_q <= 1'b0;
                        addr_q   <= bus.i_addr;
                        mem_re_q <= 1'b1;
                        mem_we_q <= 1'b0;
                    end
                end
                ST_I_BUSY, ST_D_BUSY: begin
                    // Completion or watchdog abort both close the grant.
                    if (bus.mem_rdy || w_expire) begin
                        state_q  <= ST_TURN;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end
                end
                ST_TURN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdy     = (state_q == ST_I_BUSY) & bus.mem_rdy;
    assign bus.d_rdy     = (state_q == ST_D_BUSY) & bus.mem_rdy;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.d_inProg  = (state_q == ST_D_BUSY) | ((state_q == ST_IDLE) & w_d_wins);
    assign bus.wdog_err  = w_wdog_err;

endmodule : mem_arbiter
`default_nettype wire
